// File: rtl/wb_reg_bridge_if.sv
// wb_reg_bridge_if: Wishbone classic bus between the interconnect master and the register bridge slave.
interface wb_reg_bridge_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [15:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_reg_bridge.sv
// wb_reg_bridge: registers Wishbone cycles into stable address/data and one-cycle strobes for the register decoder.
module wb_reg_bridge #(
    parameter int unsigned RD_WAIT  = 1,
    parameter logic [15:0] ADDR_MIN = 16'h0001,
    parameter logic [15:0] ADDR_MAX = 16'h0010,
    parameter bit          ERR_EN   = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    wb_reg_bridge_if.slave wb,
    output logic [15:0]    addr_o,
    output logic [31:0]    wr_data_o,
    output logic [3:0]     wr_be_o,
    output logic           wr_stb_o,
    output logic           rd_stb_o,
    input  logic [31:0]    rd_data_i
);
    typedef enum logic [1:0] {IDLE, RWAIT, TERM} state_t;
    state_t      state, state_d;
    logic [2:0]  cnt, cnt_d;
    logic        ack, ack_d, err, err_d, wr_stb_d, rd_stb_d;
    logic [31:0] dat, dat_d, wr_data_d;
    logic [15:0] addr_d;
    logic [3:0]  be_d;
    logic        req, in_range;

    assign req         = wb.wb_cyc_i & wb.wb_stb_i;
    assign in_range    = wb.wb_adr_i >= ADDR_MIN && wb.wb_adr_i <= ADDR_MAX;
    assign wb.wb_ack_o = ack;
    assign wb.wb_err_o = err;
    assign wb.wb_dat_o = dat;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            cnt       <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
            dat       <= '0;
            addr_o    <= '0;
            wr_data_o <= '0;
            wr_be_o   <= '0;
            wr_stb_o  <= 1'b0;
            rd_stb_o  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ack       <= ack_d;
            err       <= err_d;
            dat       <= dat_d;
            addr_o    <= addr_d;
            wr_data_o <= wr_data_d;
            wr_be_o   <= be_d;
            wr_stb_o  <= wr_stb_d;
            rd_stb_o  <= rd_stb_d;
        end
    end

    // Terminations and strobes default low, so every pulse lasts exactly one cycle.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        dat_d     = dat;
        addr_d    = addr_o;
        wr_data_d = wr_data_o;
        be_d      = wr_be_o;
        case (state)
            IDLE: if (req) begin
                addr_d    = wb.wb_adr_i;
                wr_data_d = wb.wb_dat_i;
                be_d      = wb.wb_sel_i;
                if (!in_range) begin
                    err_d   = ERR_EN;
                    ack_d   = !ERR_EN;
                    dat_d   = ERR_EN ? dat : '0;
                    state_d = TERM;
                end else if (wb.wb_we_i) begin
                    wr_stb_d = 1'b1;
                    ack_d    = 1'b1;
                    state_d  = TERM;
                end else begin
                    rd_stb_d = 1'b1;
                    cnt_d    = 3'(RD_WAIT);
                    state_d  = RWAIT;
                end
            end
            RWAIT: if (!wb.wb_cyc_i) begin
                state_d = IDLE;
            end else if (cnt == 3'd0) begin
                dat_d   = rd_data_i;
                ack_d   = 1'b1;
                state_d = TERM;
            end else begin
                cnt_d = cnt - 3'd1;
            end
            TERM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_wb_reg_bridge.sv
// tb_wb_reg_bridge: scoreboard bench; unit 0 uses RD_WAIT=2/ERR_EN=1, unit 1 uses RD_WAIT=3/ERR_EN=0.
module tb_wb_reg_bridge;
    typedef struct {
        int          u;
        bit          is_err;
        bit          chk_dat;
        logic [31:0] dat;
        int          at;
    } term_t;
    typedef struct {
        int          u;
        bit          wr;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          at;
    } stb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0]       cyc, stb, we, ack, err, wr_stb, rd_stb;
    logic [1:0][15:0] adr, addr;
    logic [1:0][31:0] dat_w, dat_r, wr_data, rd_data;
    logic [1:0][3:0]  sel, be;
    logic [31:0]      regs [32];
    term_t tq[$];
    stb_t  sq[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc_n = 0;
    int    off = 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    for (genvar g = 0; g < 2; g++) begin : g_u
        wb_reg_bridge_if bus ();
        assign bus.wb_cyc_i = cyc[g];
        assign bus.wb_stb_i = stb[g];
        assign bus.wb_we_i  = we[g];
        assign bus.wb_adr_i = adr[g];
        assign bus.wb_dat_i = dat_w[g];
        assign bus.wb_sel_i = sel[g];
        assign ack[g]       = bus.wb_ack_o;
        assign err[g]       = bus.wb_err_o;
        assign dat_r[g]     = bus.wb_dat_o;
        assign rd_data[g]   = (addr[g] <= 16'h0010) ? regs[addr[g][4:0]] : 32'hBAD0_BAD0;
        wb_reg_bridge #(.RD_WAIT(g ? 3 : 2), .ERR_EN(g == 0)) dut (
            .clk_i(clk), .rst_n_i(rst_n), .wb(bus),
            .addr_o(addr[g]), .wr_data_o(wr_data[g]), .wr_be_o(be[g]),
            .wr_stb_o(wr_stb[g]), .rd_stb_o(rd_stb[g]), .rd_data_i(rd_data[g])
        );
    end

    // Decoder/register-bank model: register i starts at i*0x01010101, register 16 at 0x12345678.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 16) ? 32'h1234_5678 : 32'h0101_0101 * i;
        end else begin
            for (int u = 0; u < 2; u++)
                if (wr_stb[u])
                    for (int b = 0; b < 4; b++)
                        if (be[u][b]) regs[addr[u][4:0]][8*b +: 8] <= wr_data[u][8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input int u, input string tag);
        chk({tag, "_ack"}, 32'(ack[u]), 0);
        chk({tag, "_err"}, 32'(err[u]), 0);
        chk({tag, "_wr_stb"}, 32'(wr_stb[u]), 0);
        chk({tag, "_rd_stb"}, 32'(rd_stb[u]), 0);
        chk({tag, "_dat_o"}, dat_r[u], 0);
        chk({tag, "_addr"}, 32'(addr[u]), 0);
        chk({tag, "_wr_data"}, wr_data[u], 0);
        chk({tag, "_be"}, 32'(be[u]), 0);
    endtask

    task automatic access(input int u, input bit w, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit ex_err, input bit ex_stb, input int lat,
                          input logic [31:0] ex_dat, input bit hold);
        int e0;
        e0 = cyc_n + off;
        cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; adr[u] = a; dat_w[u] = d; sel[u] = s;
        if (ex_stb) sq.push_back('{u, w, a, d, s, e0});
        tq.push_back('{u, ex_err, !w && !ex_err, ex_dat, e0 + lat});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack[u] | err[u]) break;
            if (k == 19) chk("term_timeout", 0, 1);
        end
        if (hold) off = 2;
        else begin
            cyc[u] = 1'b0; stb[u] = 1'b0;
            @(negedge clk);
            off = 1;
        end
    endtask

    // Monitor: every termination and strobe must match the oldest expectation, at the expected edge.
    always @(negedge clk) begin
        term_t t;
        stb_t  s;
        for (int u = 0; u < 2; u++) begin
            if (ack[u] | err[u]) begin
                chk("ack_err_excl", 32'(ack[u] & err[u]), 0);
                if (tq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL term_spurious: unit %0d ack=%b err=%b, none expected", u, ack[u], err[u]);
                end else begin
                    t = tq.pop_front();
                    chk("term_unit", u, t.u);
                    chk("term_is_err", 32'(err[u]), 32'(t.is_err));
                    chk("term_cycle", cyc_n, t.at);
                    if (t.chk_dat) chk("term_rd_data", dat_r[u], t.dat);
                end
            end
            if (wr_stb[u] | rd_stb[u]) begin
                chk("stb_excl", 32'(wr_stb[u] & rd_stb[u]), 0);
                if (sq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL stb_spurious: unit %0d wr=%b rd=%b, none expected", u, wr_stb[u], rd_stb[u]);
                end else begin
                    s = sq.pop_front();
                    chk("stb_unit", u, s.u);
                    chk("stb_is_wr", 32'(wr_stb[u]), 32'(s.wr));
                    chk("stb_cycle", cyc_n, s.at);
                    chk("stb_addr", 32'(addr[u]), 32'(s.a));
                    if (s.wr) begin
                        chk("stb_wr_data", wr_data[u], s.d);
                        chk("stb_be", 32'(be[u]), 32'(s.be));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = '0; stb = '0; we = '0; adr = '0; dat_w = '0; sel = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        // unit 0: write, read-back, read latency, range, sel=0 write
        access(0, 1, 16'h0005, 32'hDEAD_BEEF, 4'hF, 0, 1, 0, 32'h0, 0);
        access(0, 0, 16'h0005, 32'h0, 4'hF, 0, 1, 3, 32'hDEAD_BEEF, 0);
        access(0, 0, 16'h0010, 32'h0, 4'hF, 0, 1, 3, 32'h1234_5678, 0);
        access(0, 1, 16'h0000, 32'h5555_0000, 4'hF, 1, 0, 0, 32'h0, 0);
        access(0, 0, 16'h0011, 32'h0, 4'hF, 1, 0, 0, 32'h0, 0);
        chk("oor_addr_loaded", 32'(addr[0]), 32'h0011);
        chk("err_keeps_dat", dat_r[0], 32'h1234_5678);
        access(0, 1, 16'h0007, 32'hFFFF_FFFF, 4'h0, 0, 1, 0, 32'h0, 0);
        access(0, 0, 16'h0007, 32'h0, 4'hF, 0, 1, 3, 32'h0707_0707, 0);
        // unit 1: ERR_EN=0 range and abort
        access(1, 0, 16'h0002, 32'h0, 4'hF, 0, 1, 4, 32'h0202_0202, 0);
        access(1, 0, 16'h0011, 32'h0, 4'hF, 0, 0, 0, 32'h0, 0);
        access(1, 0, 16'h0004, 32'h0, 4'hF, 0, 1, 4, 32'h0404_0404, 0);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 16'h0006;
        sq.push_back('{1, 1'b0, 16'h0006, 32'h0, 4'hF, cyc_n + 1});
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_dat_kept", dat_r[1], 32'h0404_0404);
        off = 1;
        access(1, 1, 16'h0001, 32'h0000_1111, 4'b0011, 0, 1, 0, 32'h0, 0);
        // unit 0: reset while a read sits in RWAIT
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 16'h0010; dat_w[0] = 32'hCAFE_0000;
        sq.push_back('{0, 1'b0, 16'h0010, 32'h0, 4'hF, cyc_n + 1});
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero(0, "rst_mid");
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_ack", 32'(ack[0] | err[0]), 0);
        off = 1;
        access(0, 1, 16'h0003, 32'h0000_00AA, 4'hF, 0, 1, 0, 32'h0, 0);
        // unit 0: back-to-back with cyc/stb held
        access(0, 1, 16'h0001, 32'hA1A1_A1A1, 4'hF, 0, 1, 0, 32'h0, 1);
        access(0, 0, 16'h0002, 32'h0, 4'hF, 0, 1, 3, 32'h0202_0202, 1);
        access(0, 1, 16'h0003, 32'h3333_3333, 4'b1100, 0, 1, 0, 32'h0, 1);
        access(0, 0, 16'h0004, 32'h0, 4'hF, 0, 1, 3, 32'h0404_0404, 1);
        access(0, 1, 16'h0005, 32'h5555_5555, 4'hF, 0, 1, 0, 32'h0, 1);
        access(0, 0, 16'h0006, 32'h0, 4'hF, 0, 1, 3, 32'h0606_0606, 1);
        access(0, 1, 16'h0007, 32'h7777_7777, 4'hF, 0, 1, 0, 32'h0, 1);
        access(0, 0, 16'h0008, 32'h0, 4'hF, 0, 1, 3, 32'h0808_0808, 0);
        access(0, 0, 16'h0003, 32'h0, 4'hF, 0, 1, 3, 32'h3333_00AA, 0);
        repeat (4) @(negedge clk);
        chk("term_queue_drained", tq.size(), 0);
        chk("stb_queue_drained", sq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
